reset_ctrl: RTL and testbench
=============================

// Module: reset_ctrl
// PURPOSE
//  CPU reset sequencer directly downstream of the watchdog. It takes the watchdog
//  bite and failsafe-recovery level, a board push-button and a CSR software-reset
//  request, and drives the CPU reset pulse.
//  Latches the boot-recovery select and a sticky reset-cause register on the shared
//  5-bit CSR bus.
// PARAMETERS
//  BASE_ADDR     5'h4   CSR base: +0 CAUSE, +1 SWRST, +2 CNT
//  PULSE_LEN     8'd16  cpu_rst width in ce ticks; 0 is treated as 1
//  HOLDOFF_LEN   8'd32  blanking after pulse, in ce ticks; 0 = no holdoff
//  SW_RST_VALUE  8'hc5  magic value that must be written to SWRST
//  DEBOUNCE_LEN  4'd8   button stable ticks (only with RSTCTRL_DEBOUNCE_EN)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high CPLD power-on reset
//  ce             in   1  one-cycle tick enable, shared prescaler
//  csr_a          in   5  CSR address
//  csr_di         in   8  CSR write data
//  csr_we         in   1  CSR write strobe, one cycle
//  csr_do         out  8  CSR read data, combinational, 0 when address not decoded
//  wdt_rst_req    in   1  watchdog reset output (level; high while bitten)
//  recovery_req   in   1  watchdog failsafe / force-recovery level
//  btn_n          in   1  async push-button, active low
//  cpu_rst        out  1  CPU reset, active high, registered
//  boot_recovery  out  1  recovery boot select latched at request acceptance
// BEHAVIOUR
//  - FSM states: ASSERT, HOLDOFF, IDLE. Counter cnt[7:0] is shared by ASSERT and HOLDOFF.
//  - rst: state=ASSERT, cnt=max(PULSE_LEN,1), cpu_rst=1, boot_recovery=0, cause=8'h01 (POR).
//  - Request sources, each a one-cycle event:
//    - WDT: rising edge of wdt_rst_req, registered with a previous-value flop. A held level never retriggers.
//    - BTN: falling edge of the synchronised btn_n (2-FF synchroniser).
//    - SW: csr_we at BASE_ADDR+1 with csr_di==SW_RST_VALUE. Any other value is ignored.
//  - IDLE + any request in cycle N:
//    - state=ASSERT, cnt=max(PULSE_LEN,1).
//    - Cause bits set for every source active in N.
//    - boot_recovery<=recovery_req sampled in N.
//    - cpu_rst=1 from cycle N+1.
//  - ASSERT: cnt decrements on ce. On ce with cnt==1: cpu_rst=0 next cycle, then
//    - HOLDOFF with cnt=HOLDOFF_LEN, or
//    - IDLE if HOLDOFF_LEN==0.
//  - HOLDOFF: cnt decrements on ce. On ce with cnt==1: go to IDLE.
//  - Requests in ASSERT or HOLDOFF are dropped: no cause bit set, no pulse extension.
//  - Request in the same cycle the FSM enters IDLE is dropped. Acceptance needs state==IDLE at the clock edge.
//  - Simultaneous sources: one pulse, all corresponding cause bits set.
//  - cause register:
//    - Layout {recov_latched, 3'b0, sw, btn, wdt, por}.
//    - Bits [3:0] sticky, write-1-to-clear at BASE_ADDR+0.
//    - Set has priority over clear in the same cycle.
//    - Bit 7 mirrors boot_recovery and is read-only.
//  - CNT (+2) reads cnt; writes ignored. SWRST reads 0.
//  - cpu_rst does not reset this block; only rst does, so cause survives CPU resets.
// CONFIGURATION
//  RSTCTRL_DEBOUNCE_EN:
//  - Defined: synchronised btn_n must be stable for DEBOUNCE_LEN consecutive ce ticks
//    before the filtered level changes. BTN is the falling edge of the filtered level.
//  - Undefined: no filter; BTN is the falling edge of the 2-FF output.
//  - The DEBOUNCE_LEN parameter is unused when the macro is undefined.
// TESTING
//  - POR: release rst, ce every cycle, PULSE_LEN=16:
//    - cpu_rst high through the 16th ce tick.
//    - Then low for 32 ticks of holdoff, then IDLE.
//    - CAUSE reads 8'h01.
//  - WDT bite:
//    - In IDLE raise wdt_rst_req with recovery_req=1 -> cpu_rst=1 next cycle, 16 ticks wide.
//    - CAUSE=8'h83, boot_recovery=1.
//    - wdt_rst_req held high afterwards -> no second pulse.
//  - SW reset:
//    - Write 8'h00 to +1 -> nothing.
//    - Write 8'hc5 -> pulse; CAUSE bit3 set.
//    - Write 8'h0f to +0 -> CAUSE reads 8'h80, or 8'h00 if boot_recovery=0.
//  - Blanking: SW request during ASSERT and again mid-HOLDOFF -> no extension, no new cause bit, CNT keeps counting down.
//  - Simultaneous:
//    - WDT edge + SW write in the same IDLE cycle -> single pulse, CAUSE[3:0]=4'b1010.
//    - W1C to bit1 in the cycle bit1 is set -> bit1 stays 1.
//  - Button, with RSTCTRL_DEBOUNCE_EN:
//    - 3-tick low glitch -> ignored.
//    - 10-tick low -> pulse, CAUSE bit2 set.
//    - Without the macro, the 3-tick glitch triggers a pulse.

Source files
------------

// File: rtl/reset_ctrl_if.sv
// ----------------------------------------------------------------------------
// reset_ctrl_if
//   CSR bus shared with the reset sequencer (5-bit address, 8-bit data).
//
//   Signals
//     csr_a   5  address, driven by the bus master
//     csr_di  8  write data, driven by the bus master
//     csr_we  1  write strobe, one cycle per write
//     csr_do  8  read data, combinational from csr_a, 0 when not decoded
//
//   Handshake: csr_we acts as a one-cycle valid with an implicit ready that is
//   always high. A write is consumed on the rising clk edge where csr_we=1,
//   and there is no back-pressure. Reads have no strobe: csr_do follows
//   csr_a combinationally within the same cycle.
//
//   Modports
//     master  drives address/data/strobe, receives read data
//     slave   receives address/data/strobe, drives read data
// ----------------------------------------------------------------------------
interface reset_ctrl_if;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;

    modport master (
        output csr_a,
        output csr_di,
        output csr_we,
        input  csr_do
    );

    modport slave (
        input  csr_a,
        input  csr_di,
        input  csr_we,
        output csr_do
    );
endinterface

// File: rtl/reset_ctrl.sv
// ----------------------------------------------------------------------------
// reset_ctrl
//   CPU reset sequencer sitting directly behind the watchdog. Three request
//   sources (watchdog bite edge, push-button press, CSR software reset) start
//   a CPU reset pulse followed by a blanking window. It also latches the
//   recovery-boot select and keeps a sticky reset-cause register.
//
//   CSR map (relative to BASE_ADDR)
//     +0 CAUSE  {recov_latched, 3'b0, sw, btn, wdt, por}; [3:0] W1C, [7] RO
//     +1 SWRST  write SW_RST_VALUE to request a reset; reads 0
//     +2 CNT    current ASSERT/HOLDOFF counter; read-only
//
//   Ports
//     clk            system clock
//     rst            synchronous active-high power-on reset
//     ce             one-cycle tick enable from the shared prescaler
//     csr            CSR bus (reset_ctrl_if.slave)
//     wdt_rst_req    watchdog reset level (high while bitten)
//     recovery_req   failsafe / force-recovery level
//     btn_n          asynchronous push-button, active low
//     cpu_rst        CPU reset, active high, registered
//     boot_recovery  recovery boot select latched at request acceptance
//     dbg_state      current FSM state (state_t encoding)
//
//   Build option
//     RSTCTRL_DEBOUNCE_EN  when defined, the synchronised button must stay at
//                          a new level for DEBOUNCE_LEN consecutive ce ticks
//                          before the filtered level follows it. When not
//                          defined the synchroniser output is used directly
//                          and DEBOUNCE_LEN has no effect.
// ----------------------------------------------------------------------------
module reset_ctrl #(
    parameter logic [4:0] BASE_ADDR    = 5'h4,
    parameter logic [7:0] PULSE_LEN    = 8'd16,
    parameter logic [7:0] HOLDOFF_LEN  = 8'd32,
    parameter logic [7:0] SW_RST_VALUE = 8'hc5,
    parameter logic [3:0] DEBOUNCE_LEN = 4'd8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    reset_ctrl_if.slave        csr,
    input  logic               wdt_rst_req,
    input  logic               recovery_req,
    input  logic               btn_n,
    output logic               cpu_rst,
    output logic               boot_recovery,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    localparam logic [4:0] ADDR_CAUSE = BASE_ADDR;
    localparam logic [4:0] ADDR_SWRST = BASE_ADDR + 5'd1;
    localparam logic [4:0] ADDR_CNT   = BASE_ADDR + 5'd2;

    // A zero pulse length still has to produce a visible reset.
    localparam logic [7:0] PULSE_INIT = (PULSE_LEN == 8'd0) ? 8'd1 : PULSE_LEN;

    // ------------------------------------------------------------------
    // Request sources
    // ------------------------------------------------------------------
    logic wdt_prev;
    logic wdt_ev;

    logic btn_s1;
    logic btn_s2;
    logic btn_filt;
    logic btn_prev;
    logic btn_ev;

    logic sw_ev;
    logic any_req;

    // Watchdog: only the rising edge requests; a held level is one request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_prev <= 1'b0;
        end else begin
            wdt_prev <= wdt_rst_req;
        end
    end

    assign wdt_ev = wdt_rst_req & ~wdt_prev;

    // Button synchroniser. Resets to the released (high) level so that a
    // button already pressed at power-up is seen as a press afterwards only
    // if the FSM is idle by then.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
        end
    end

`ifdef RSTCTRL_DEBOUNCE_EN
    localparam logic [3:0] DB_LEN = (DEBOUNCE_LEN == 4'd0) ? 4'd1 : DEBOUNCE_LEN;

    logic [3:0] db_cnt;
    logic       db_level;

    // db_cnt counts consecutive ce ticks on which the synchronised input
    // disagrees with the filtered level; any agreeing tick restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_level <= 1'b1;
            db_cnt   <= 4'd0;
        end else if (ce) begin
            if (btn_s2 == db_level) begin
                db_cnt <= 4'd0;
            end else if (db_cnt == DB_LEN - 4'd1) begin
                db_level <= btn_s2;
                db_cnt   <= 4'd0;
            end else begin
                db_cnt <= db_cnt + 4'd1;
            end
        end
    end

    assign btn_filt = db_level;
`else
    assign btn_filt = btn_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= 1'b1;
        end else begin
            btn_prev <= btn_filt;
        end
    end

    // Press = falling edge of the (possibly filtered) active-low level.
    assign btn_ev = btn_prev & ~btn_filt;

    assign sw_ev = csr.csr_we && (csr.csr_a == ADDR_SWRST) &&
                   (csr.csr_di == SW_RST_VALUE);

    assign any_req = wdt_ev | btn_ev | sw_ev;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= PULSE_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt is shared by ASSERT and HOLDOFF. Requests are only looked at in
    // IDLE, so anything arriving during the pulse or the blanking window
    // (including the cycle that returns to IDLE) is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                if (ce) begin
                    if (cnt_q <= 8'd1) begin
                        if (HOLDOFF_LEN == 8'd0) begin
                            state_d = ST_IDLE;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = HOLDOFF_LEN;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (ce) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (any_req) begin
                    accept  = 1'b1;
                    state_d = ST_ASSERT;
                    cnt_d   = PULSE_INIT;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = PULSE_INIT;
            end
        endcase
    end

    // cpu_rst is a registered image of "next state is ASSERT", so it rises
    // the cycle after acceptance and falls the cycle after the last tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst <= 1'b1;
        end else begin
            cpu_rst <= (state_d == ST_ASSERT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            boot_recovery <= 1'b0;
        end else if (accept) begin
            boot_recovery <= recovery_req;
        end
    end

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Cause register: bits {sw, btn, wdt, por}. Only rst clears it to POR,
    // cpu_rst never touches this block, so the cause survives CPU resets.
    // A set in the same cycle as a W1C of that bit wins.
    // ------------------------------------------------------------------
    logic [3:0] cause_q;
    logic [3:0] cause_set;
    logic [3:0] cause_clr;

    always_comb begin
        cause_set = 4'b0000;
        cause_clr = 4'b0000;
        if (accept) begin
            cause_set = {sw_ev, btn_ev, wdt_ev, 1'b0};
        end
        if (csr.csr_we && (csr.csr_a == ADDR_CAUSE)) begin
            cause_clr = csr.csr_di[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= 4'b0001;
        end else begin
            cause_q <= (cause_q & ~cause_clr) | cause_set;
        end
    end

    // ------------------------------------------------------------------
    // CSR read mux (SWRST and undecoded addresses read as 0)
    // ------------------------------------------------------------------
    always_comb begin
        csr.csr_do = 8'h00;
        if (csr.csr_a == ADDR_CAUSE) begin
            csr.csr_do = {boot_recovery, 3'b000, cause_q};
        end else if (csr.csr_a == ADDR_CNT) begin
            csr.csr_do = cnt_q;
        end
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// ----------------------------------------------------------------------------
// tb_reset_ctrl
//   Bench for reset_ctrl with default parameters (BASE_ADDR 4, pulse 16,
//   holdoff 32, magic 8'hc5). Directed sequences cover power-on, watchdog
//   bite, CSR decode table, software reset with blanking, simultaneous
//   sources and the button path; a random phase follows, checked against a
//   tick-budget model of the reset window.
// ----------------------------------------------------------------------------
module tb_reset_ctrl;

    localparam int P_TICKS = 16;
    localparam int H_TICKS = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ce = 1'b0;
    logic       wdt_rst_req = 1'b0;
    logic       recovery_req = 1'b0;
    logic       btn_n = 1'b1;
    logic       cpu_rst;
    logic       boot_recovery;
    logic [1:0] dbg_state;

    reset_ctrl_if bus ();

    reset_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .csr           (bus),
        .wdt_rst_req   (wdt_rst_req),
        .recovery_req  (recovery_req),
        .btn_n         (btn_n),
        .cpu_rst       (cpu_rst),
        .boot_recovery (boot_recovery),
        .dbg_state     (dbg_state)
    );

    int total = 0;
    int bad = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        ce = 1'b1;
        repeat (n) step();
        ce = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        bus.csr_we = 1'b1;
        bus.csr_a  = a;
        bus.csr_di = d;
        step();
        bus.csr_we = 1'b0;
        bus.csr_di = 8'h00;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        bus.csr_a = a;
        #1;
        d = bus.csr_do;
    endtask

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] act);
        logic [7:0] exp;
        exp = exp_q.pop_front();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_csr(input string name, input logic [4:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        exp_q.push_back(exp);
        check(name, d);
    endtask

    task automatic chk_rst(input string name, input logic exp);
        exp_q.push_back({7'b0, exp});
        check(name, {7'b0, cpu_rst});
    endtask

    task automatic chk_brec(input string name, input logic exp);
        exp_q.push_back({7'b0, exp});
        check(name, {7'b0, boot_recovery});
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        exp_q.push_back(exp[7:0]);
        check(name, act[7:0]);
    endtask

    // ---------------- CSR table ----------------
    typedef struct {
        logic       we;
        logic [4:0] a;
        logic [7:0] di;
        logic [4:0] rd_a;
        logic [7:0] exp_do;
    } vec_t;

    vec_t vecs[14];

    // ---------------- button trial ----------------
    task automatic btn_trial(input int low_n, output int hi);
        hi = 0;
        ce = 1'b1;
        for (int i = 0; i < 80; i++) begin
            btn_n = (i < low_n) ? 1'b0 : 1'b1;
            #1;
            if (cpu_rst) hi++;
            step();
        end
        ce = 1'b0;
        btn_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // The reset window is a budget of ce ticks: PULSE+HOLDOFF ticks after an
    // accepted request, with the reset line high while more than HOLDOFF
    // ticks remain. Requests are honoured only when the budget is empty.
    int         m_rem;
    logic [3:0] m_cause;
    logic       m_brec;
    logic       m_wprev;

    function automatic logic [7:0] m_read(input logic [4:0] a);
        if (a == 5'd4) return {m_brec, 3'b000, m_cause};
        if (a == 5'd6) return (m_rem > H_TICKS) ? 8'(m_rem - H_TICKS) : 8'(m_rem);
        return 8'h00;
    endfunction

    task automatic m_reset();
        m_rem   = P_TICKS + H_TICKS;
        m_cause = 4'b0001;
        m_brec  = 1'b0;
        m_wprev = 1'b0;
    endtask

    task automatic m_clock();
        logic w_ev;
        logic s_ev;
        logic [3:0] clr;
        w_ev = wdt_rst_req && !m_wprev;
        s_ev = bus.csr_we && bus.csr_a == 5'd5 && bus.csr_di == 8'hc5;
        clr  = (bus.csr_we && bus.csr_a == 5'd4) ? bus.csr_di[3:0] : 4'b0000;
        m_cause = m_cause & ~clr;
        if (m_rem == 0) begin
            if (w_ev || s_ev) begin
                m_rem = P_TICKS + H_TICKS;
                if (w_ev) m_cause[1] = 1'b1;
                if (s_ev) m_cause[3] = 1'b1;
                m_brec = recovery_req;
            end
        end else if (ce) begin
            m_rem--;
        end
        m_wprev = wdt_rst_req;
    endtask

    // ---------------- main ----------------
    initial begin
        int hi;
        bus.csr_a  = 5'd0;
        bus.csr_di = 8'h00;
        bus.csr_we = 1'b0;

        vecs[0]  = '{1'b0, 5'd0, 8'h00, 5'd4, 8'h83};
        vecs[1]  = '{1'b0, 5'd0, 8'h00, 5'd5, 8'h00};
        vecs[2]  = '{1'b0, 5'd0, 8'h00, 5'd6, 8'h00};
        vecs[3]  = '{1'b0, 5'd0, 8'h00, 5'd3, 8'h00};
        vecs[4]  = '{1'b0, 5'd0, 8'h00, 5'd7, 8'h00};
        vecs[5]  = '{1'b1, 5'd5, 8'h00, 5'd4, 8'h83};
        vecs[6]  = '{1'b1, 5'd5, 8'hc4, 5'd6, 8'h00};
        vecs[7]  = '{1'b1, 5'd6, 8'hff, 5'd6, 8'h00};
        vecs[8]  = '{1'b1, 5'd4, 8'h00, 5'd4, 8'h83};
        vecs[9]  = '{1'b1, 5'd4, 8'h0d, 5'd4, 8'h82};
        vecs[10] = '{1'b1, 5'd4, 8'h02, 5'd4, 8'h80};
        vecs[11] = '{1'b1, 5'd4, 8'hf0, 5'd4, 8'h80};
        vecs[12] = '{1'b1, 5'd7, 8'hc5, 5'd4, 8'h80};
        vecs[13] = '{1'b1, 5'd1, 8'hc5, 5'd4, 8'h80};

        // ---- power-on reset ----
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        ce  = 1'b1;
        for (int i = 0; i < P_TICKS; i++) begin
            chk_rst("por_pulse", 1'b1);
            chk_csr("por_cnt_assert", 5'd6, 8'(P_TICKS - i));
            step();
        end
        for (int j = 0; j < H_TICKS; j++) begin
            chk_rst("por_holdoff_rst", 1'b0);
            chk_csr("por_cnt_holdoff", 5'd6, 8'(H_TICKS - j));
            step();
        end
        ce = 1'b0;
        chk_csr("por_cnt_idle", 5'd6, 8'h00);
        chk_csr("por_cause", 5'd4, 8'h01);
        chk_brec("por_brec", 1'b0);

        // ---- watchdog bite with recovery ----
        recovery_req = 1'b1;
        wdt_rst_req  = 1'b1;
        step();
        recovery_req = 1'b0;
        chk_rst("wdt_rst_next", 1'b1);
        chk_brec("wdt_brec", 1'b1);
        chk_csr("wdt_cause", 5'd4, 8'h83);
        chk_csr("wdt_cnt", 5'd6, 8'h10);
        hi = 0;
        ce = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (cpu_rst) hi++;
            step();
        end
        ce = 1'b0;
        chk_int("wdt_pulse_width_held", hi, P_TICKS);
        chk_rst("wdt_no_retrigger", 1'b0);
        chk_csr("wdt_cnt_idle", 5'd6, 8'h00);

        // ---- CSR decode table ----
        for (int k = 0; k < 14; k++) begin
            bus.csr_we = vecs[k].we;
            bus.csr_a  = vecs[k].a;
            bus.csr_di = vecs[k].di;
            step();
            bus.csr_we = 1'b0;
            chk_csr($sformatf("table_%0d", k), vecs[k].rd_a, vecs[k].exp_do);
            chk_rst($sformatf("table_rst_%0d", k), 1'b0);
        end

        // ---- software reset and blanking ----
        wr(5'd5, 8'hc5);
        chk_rst("sw_rst", 1'b1);
        chk_brec("sw_brec", 1'b0);
        chk_csr("sw_cause", 5'd4, 8'h08);
        chk_csr("sw_cnt", 5'd6, 8'h10);
        wr(5'd4, 8'h0f);
        chk_csr("sw_w1c", 5'd4, 8'h00);
        tick(5);
        chk_csr("blank_cnt_a", 5'd6, 8'd11);
        wr(5'd5, 8'hc5);
        chk_csr("blank_assert_cnt", 5'd6, 8'd11);
        chk_csr("blank_assert_cause", 5'd4, 8'h00);
        chk_rst("blank_assert_rst", 1'b1);
        tick(11);
        chk_rst("blank_pulse_end", 1'b0);
        chk_csr("blank_hold_cnt", 5'd6, 8'd32);
        tick(10);
        wr(5'd5, 8'hc5);
        chk_csr("blank_hold_cnt2", 5'd6, 8'd22);
        chk_csr("blank_hold_cause", 5'd4, 8'h00);
        chk_rst("blank_hold_rst", 1'b0);
        tick(21);
        chk_csr("blank_last_tick", 5'd6, 8'd1);
        ce = 1'b1;
        wr(5'd5, 8'hc5);
        ce = 1'b0;
        chk_csr("idle_entry_cnt", 5'd6, 8'h00);
        chk_csr("idle_entry_cause", 5'd4, 8'h00);
        step();
        chk_rst("idle_entry_dropped", 1'b0);

        // ---- simultaneous sources ----
        wdt_rst_req = 1'b0;
        step();
        wdt_rst_req = 1'b1;
        wr(5'd5, 8'hc5);
        chk_rst("simul_rst", 1'b1);
        chk_csr("simul_cause", 5'd4, 8'h0a);
        hi = 0;
        ce = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cpu_rst) hi++;
            step();
        end
        ce = 1'b0;
        chk_int("simul_single_pulse", hi, P_TICKS);
        wr(5'd4, 8'h0f);
        chk_csr("simul_w1c", 5'd4, 8'h00);
        wdt_rst_req = 1'b0;
        step();
        wdt_rst_req = 1'b1;
        wr(5'd4, 8'h02);
        chk_csr("set_beats_clear", 5'd4, 8'h02);
        chk_rst("set_beats_clear_rst", 1'b1);
        tick(48);
        wdt_rst_req = 1'b0;
        wr(5'd4, 8'h0f);
        chk_csr("pre_btn_cause", 5'd4, 8'h00);

        // ---- button ----
        btn_trial(3, hi);
`ifdef RSTCTRL_DEBOUNCE_EN
        chk_int("btn_glitch_pulse", hi, 0);
        chk_csr("btn_glitch_cause", 5'd4, 8'h00);
`else
        chk_int("btn_glitch_pulse", hi, P_TICKS);
        chk_csr("btn_glitch_cause", 5'd4, 8'h04);
`endif
        wr(5'd4, 8'h0f);
        btn_trial(10, hi);
        chk_int("btn_press_pulse", hi, P_TICKS);
        chk_csr("btn_press_cause", 5'd4, 8'h04);
        chk_rst("btn_press_done", 1'b0);

        // ---- random phase against the model ----
        rst = 1'b1;
        ce = 1'b0;
        wdt_rst_req = 1'b0;
        recovery_req = 1'b0;
        btn_n = 1'b1;
        repeat (2) step();
        m_reset();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] d;
            ce = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) wdt_rst_req = ~wdt_rst_req;
            recovery_req = 1'($urandom_range(0, 1));
            bus.csr_we = ($urandom_range(0, 7) == 0);
            bus.csr_a  = 5'($urandom_range(3, 7));
            bus.csr_di = ($urandom_range(0, 2) == 0) ? 8'hc5 : 8'($urandom_range(0, 255));
            #1;
            d = bus.csr_do;
            exp_q.push_back(m_read(bus.csr_a));
            check("rnd_csr_do", d);
            chk_rst("rnd_cpu_rst", m_rem > H_TICKS);
            chk_brec("rnd_brec", m_brec);
            m_clock();
            step();
        end
        bus.csr_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
